wb_stage_regfile: RTL
=====================

// Module: wb_stage_regfile
// PURPOSE
//  Consumer end of the MEM/WB pipeline register in the 8-bit pipelined core.
//  - Selects the writeback value (ALU result, memory data, input port, PC+1).
//  - Commits that value into a 4x8 register file; R3 is the stack pointer.
//  - Latches Rd2 into the output-port register on IO_Write.
//  - Serves the two decode-stage read ports, with write-before-read bypass.
//  - Exports the writeback bus so the forwarding unit can use it.
// PARAMETERS
//  DW       8      datapath width
//  NREG     4      register count; the address width is clog2(NREG) = 2
//  SP_IDX   3      index of the stack-pointer register
//  SP_INIT  8'hFF  reset value of the stack-pointer register
// PORTS
//  clk           in   1   single clock; all state updates on the rising edge
//  rst           in   1   reset, asynchronous, active-high
//  wb_pc_plus1   in   8   PC+1 from MEM/WB
//  wb_dest       in   2   destination register index from MEM/WB
//  wb_rd2        in   8   store/out operand from MEM/WB
//  wb_alu_res    in   8   ALU result from MEM/WB
//  wb_mem_data   in   8   memory read data from MEM/WB
//  wb_mem_to_reg in   2   writeback source select
//  wb_reg_write  in   1   register write enable
//  wb_ip         in   8   sampled input-port value from MEM/WB
//  wb_io_write   in   1   output-port write enable
//  ra_addr       in   2   read port A address (decode stage)
//  rb_addr       in   2   read port B address (decode stage)
//  ra_data       out  8   read port A data (combinational)
//  rb_data       out  8   read port B data (combinational)
//  fwd_data      out  8   selected writeback value (combinational)
//  fwd_dest      out  2   equals wb_dest
//  fwd_we        out  1   equals wb_reg_write
//  out_port      out  8   output-port register
//  out_strobe    out  1   one-cycle pulse when out_port updates
// BEHAVIOUR
//  - Source select (combinational):
//    - 00: wb_alu_res
//    - 01: wb_mem_data
//    - 10: wb_ip
//    - 11: wb_pc_plus1
//  - Register write: on the rising edge when wb_reg_write=1, R[wb_dest] <= fwd_data.
//    wb_dest=SP_IDX overwrites the SP like any other register.
//  - Read ports are combinational. When wb_reg_write=1 and the read address
//    equals wb_dest, the port returns fwd_data in the same cycle (bypass).
//    Both ports may bypass at the same time.
//  - Output port: on the rising edge when wb_io_write=1, out_port <= wb_rd2 and
//    out_strobe <= 1; otherwise out_strobe <= 0 and out_port holds.
//    Back-to-back IO writes give out_strobe high on consecutive cycles.
//  - Simultaneous wb_reg_write and wb_io_write: both take effect in the same cycle.
//  - Latency: register commit and out_port update take 1 cycle; reads and bypass
//    take 0 cycles.
//  - Reset values while rst=1, independent of clk:
//    - R0..R2 = 0; R[SP_IDX] = SP_INIT
//    - out_port = 0; out_strobe = 0
//    - ra_data/rb_data reflect the reset register contents
//  - Reset asserted mid-operation discards any commit pending on that edge.
//    Release is synchronous to the next rising edge.
//  - All arithmetic is 8-bit; this block performs no arithmetic.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_IP=2'b10, MTR_PC1=2'b11
//    - SP_IDX, SP_INIT, DW
//  - Sub-module regfile_4x8: storage, write port, two read ports with bypass.
//  - The top level holds the writeback mux, the output-port register and the
//    strobe flop.
// TESTING
//  1. Reset: assert rst with no clock -> R0..R2=0, R3=8'hFF, out_port=0,
//     out_strobe=0; read ra=3 returns 8'hFF.
//  2. Source select: alu_res=8'h12, mem=8'h34, ip=8'h56, pc1=8'h78, dest=1,
//     we=1; sweep mem_to_reg 0..3 -> R1 reads 8'h12, 8'h34, 8'h56, 8'h78
//     after each edge.
//  3. Bypass: we=1, dest=2, alu_res=8'hA5, ra=rb=2 in the same cycle ->
//     ra_data=rb_data=8'hA5 before the edge; with we=0 both ports return old R2.
//  4. IO write: io_write=1, rd2=8'h3C for 2 cycles, then 0 -> out_port=8'h3C,
//     out_strobe high exactly 2 cycles, then out_port holds 8'h3C.
//  5. Simultaneous: we=1, dest=0, io_write=1, rd2=8'h99, alu_res=8'h11 ->
//     R0=8'h11 and out_port=8'h99 after one edge.
//  6. Mid-op reset: assert rst between edges while we=1, dest=3 -> R3 returns
//     to 8'hFF asynchronously and the pending write is lost.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 8-bit pipelined core: datapath width, register
// file geometry, stack-pointer location/reset value and the writeback source
// select encoding used by the MEM/WB consumer.
package cpu_pkg;

    localparam int DW      = 8;
    localparam int NREG    = 4;
    localparam int AW      = $clog2(NREG);
    localparam int SP_IDX  = 3;
    localparam logic [DW-1:0] SP_INIT = 8'hFF;

    // Writeback source select
    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_IP  = 2'b10,
        MTR_PC1 = 2'b11
    } mtr_e;

endpackage

// File: rtl/regfile_4x8.sv
// regfile_4x8
// Four 8-bit registers with one synchronous write port and two combinational
// read ports. A read that hits the register being written this cycle returns
// the write data directly, so decode sees the value before it is committed.
// Ports:
//   clk, rst                 clock, async active-high reset
//   we_i, waddr_i, wdata_i   write port (commits on rising edge)
//   ra_addr_i, ra_data_o     read port A (combinational, bypassed)
//   rb_addr_i, rb_data_o     read port B (combinational, bypassed)
module regfile_4x8
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] ra_addr_i,
    input  logic [AW-1:0] rb_addr_i,
    output logic [DW-1:0] ra_data_o,
    output logic [DW-1:0] rb_data_o
);

    logic [DW-1:0] regs_q [NREG];

    // Storage. The stack pointer resets to the top of memory, the rest to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Write-before-read bypass; each port checks independently so both can
    // hit at once.
    always_comb begin
        ra_data_o = regs_q[ra_addr_i];
        rb_data_o = regs_q[rb_addr_i];
        if (we_i && (ra_addr_i == waddr_i)) ra_data_o = wdata_i;
        if (we_i && (rb_addr_i == waddr_i)) rb_data_o = wdata_i;
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile
// Consumer end of the MEM/WB pipeline register. Selects the writeback value,
// commits it to the register file, latches the output port and exports the
// writeback bus to the forwarding unit.
// Ports:
//   clk, rst                         clock, async active-high reset
//   wb_*                             MEM/WB pipeline register fields
//   ra_addr/ra_data, rb_addr/rb_data decode-stage read ports
//   fwd_data, fwd_dest, fwd_we       writeback bus for forwarding
//   out_port, out_strobe             output-port register and update pulse
module wb_stage_regfile
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wb_pc_plus1,
    input  logic [AW-1:0] wb_dest,
    input  logic [DW-1:0] wb_rd2,
    input  logic [DW-1:0] wb_alu_res,
    input  logic [DW-1:0] wb_mem_data,
    input  logic [1:0]    wb_mem_to_reg,
    input  logic          wb_reg_write,
    input  logic [DW-1:0] wb_ip,
    input  logic          wb_io_write,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic [DW-1:0] fwd_data,
    output logic [AW-1:0] fwd_dest,
    output logic          fwd_we,
    output logic [DW-1:0] out_port,
    output logic          out_strobe
);

    logic [DW-1:0] wbData;
    logic [DW-1:0] outPort_q;
    logic          outStrobe_q;

    // Writeback source mux
    always_comb begin
        wbData = wb_alu_res;
        unique case (mtr_e'(wb_mem_to_reg))
            MTR_ALU: wbData = wb_alu_res;
            MTR_MEM: wbData = wb_mem_data;
            MTR_IP:  wbData = wb_ip;
            MTR_PC1: wbData = wb_pc_plus1;
            default: wbData = wb_alu_res;
        endcase
    end

    regfile_4x8 uRegfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_reg_write),
        .waddr_i   (wb_dest),
        .wdata_i   (wbData),
        .ra_addr_i (ra_addr),
        .rb_addr_i (rb_addr),
        .ra_data_o (ra_data),
        .rb_data_o (rb_data)
    );

    // Output port: strobe is high only on cycles that follow an IO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outPort_q   <= '0;
            outStrobe_q <= 1'b0;
        end else begin
            outStrobe_q <= wb_io_write;
            if (wb_io_write) outPort_q <= wb_rd2;
        end
    end

    assign fwd_data   = wbData;
    assign fwd_dest   = wb_dest;
    assign fwd_we     = wb_reg_write;
    assign out_port   = outPort_q;
    assign out_strobe = outStrobe_q;

endmodule
